myo_status_recorder: RTL and testbench

// Consumer stage of the MYO motor control block: on every completed SPI exchange (the per-motor update strobe)
// it captures motor index, position, velocity, current and spring displacement, tags the record with a

---
 rtl/myo_status_recorder_pkg.sv | 42 ++++
 rtl/myo_status_recorder_ram.sv | 32 +++
 rtl/myo_status_recorder.sv | 168 ++++++++++++++++
 tb/tb_myo_status_recorder.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/myo_status_recorder_pkg.sv
// Shared register map, record layout and word selection for the status recorder.
// Latency: not applicable (constants, types and a pure function only).
// Backpressure: not applicable.
package myo_status_recorder_pkg;

    localparam logic [3:0] ADDR_DATA      = 4'd0;
    localparam logic [3:0] ADDR_FILL      = 4'd1;
    localparam logic [3:0] ADDR_STATUS    = 4'd2;
    localparam logic [3:0] ADDR_DROPPED   = 4'd3;
    localparam logic [3:0] ADDR_MASK      = 4'd4;
    localparam logic [3:0] ADDR_THRESHOLD = 4'd5;
    localparam logic [3:0] ADDR_CONTROL   = 4'd6;

    localparam logic [1:0] WORD_HDR    = 2'd0;
    localparam logic [1:0] WORD_POS    = 2'd1;
    localparam logic [1:0] WORD_VELCUR = 2'd2;
    localparam logic [1:0] WORD_DISP   = 2'd3;

    localparam logic [31:0] BAD_CODE = 32'hDEADBEEF;
    localparam int          TS_W     = 24;

    // One telemetry record; w0 sits in the low bits of the packed vector.
    typedef struct packed {
        logic [31:0] w3;   // {16'h0, displacement}
        logic [31:0] w2;   // {velocity, current}
        logic [31:0] w1;   // position
        logic [31:0] w0;   // {motor, timestamp}
    } rec_t;

    function automatic logic [31:0] rec_word(input rec_t r, input logic [1:0] idx);
        logic [31:0] w;
        case (idx)
            WORD_HDR:    w = r.w0;
            WORD_POS:    w = r.w1;
            WORD_VELCUR: w = r.w2;
            WORD_DISP:   w = r.w3;
            default:     w = r.w0;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/myo_status_recorder_ram.sv
// Simple dual-port record store: one write port, one registered read port.
// Latency: read data valid one cycle after raddr; a same-cycle write to raddr is forwarded.
// Backpressure: none; the caller guarantees it never writes a live slot.
module myo_status_recorder_ram
    import myo_status_recorder_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = $bits(rec_t)
) (
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port.
    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // Registered read; forwarding keeps a freshly written head visible next cycle.
    always_ff @(posedge clock) begin
        if (we && (waddr == raddr)) rdata <= wdata;
        else                        rdata <= mem[raddr];
    end

endmodule

// File: rtl/myo_status_recorder.sv
// Captures per-motor SPI samples with a microsecond timestamp into a record FIFO drained over Avalon-MM.
// Latency: sample strobe to FILL/irq_level one cycle; every Avalon read takes one wait state.
// Backpressure: none on samples (full FIFO drops and counts); reads stall via waitrequest.
module myo_status_recorder #(
    parameter int NUMBER_OF_MOTORS = 7,
    parameter int DEPTH            = 64,
    parameter int CLOCK_SPEED_HZ   = 50_000_000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        sample_valid,
    input  logic [7:0]  sample_motor,
    input  logic [31:0] sample_position,
    input  logic [15:0] sample_velocity,
    input  logic [15:0] sample_current,
    input  logic [15:0] sample_displacement,
    input  logic [3:0]  address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        waitrequest,
    output logic        irq_level
);
    import myo_status_recorder_pkg::*;

    localparam int          AW         = $clog2(DEPTH);
    localparam int          PRESC      = CLOCK_SPEED_HZ / 1_000_000;
    localparam logic [31:0] PRESC_LAST = 32'(PRESC - 1);
    localparam logic [7:0]  NM         = 8'(NUMBER_OF_MOTORS);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] PTR_ONE    = (AW+1)'(1);

    logic [31:0]     prescaler;
    logic [TS_W-1:0] ts;
    logic [AW:0]     wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, fill;
    logic [1:0]      word_idx;
    logic            en, overflow, rd_phase, rd_hit;
    logic [31:0]     mask, dropped, rd_mux;
    logic [15:0]     threshold;
    logic            empty, full, capture, push, pop, drop;
    logic            rd_acc, wr_acc, flush, clear;
    rec_t            new_rec, head_rec;
    logic [127:0]    ram_q;

    assign fill  = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (fill == FULL_COUNT);

    assign waitrequest = read && !rd_phase;
    assign rd_acc      = read && rd_phase;
    assign wr_acc      = write && !waitrequest;
    assign flush       = wr_acc && (address == ADDR_STATUS) && writedata[0];
    assign clear       = wr_acc && (address == ADDR_STATUS) && writedata[1];

    // A pop that frees the head slot in the same cycle lets a push into a full FIFO go through.
    assign capture = sample_valid && en && (sample_motor < NM) && mask[sample_motor[4:0]];
    assign pop     = rd_acc && rd_hit && (word_idx == WORD_DISP);
    assign push    = capture && !flush && (!full || pop);
    assign drop    = capture && !flush && full && !pop;

    assign wr_ptr_nxt = push  ? (wr_ptr + PTR_ONE) : wr_ptr;
    assign rd_ptr_nxt = flush ? wr_ptr : (pop ? (rd_ptr + PTR_ONE) : rd_ptr);

    assign irq_level = (threshold != 16'd0) && (32'(fill) >= 32'(threshold));

    assign new_rec.w0 = {sample_motor, ts};
    assign new_rec.w1 = sample_position;
    assign new_rec.w2 = {sample_velocity, sample_current};
    assign new_rec.w3 = {16'h0, sample_displacement};
    assign head_rec   = ram_q;

    // Reading the look-ahead pointer keeps ram_q equal to the current head every cycle.
    myo_status_recorder_ram #(.DEPTH(DEPTH), .AW(AW), .W(128)) u_ram (
        .clock (clock),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (new_rec),
        .raddr (rd_ptr_nxt[AW-1:0]),
        .rdata (ram_q)
    );

    // Microsecond timestamp from a clock prescaler.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= 32'd0;
            ts        <= '0;
        end else if (prescaler == PRESC_LAST) begin
            prescaler <= 32'd0;
            ts        <= ts + 24'd1;
        end else begin
            prescaler <= prescaler + 32'd1;
        end
    end

    // FIFO pointers and the word cursor within the head record.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            word_idx <= WORD_HDR;
        end else begin
            wr_ptr <= wr_ptr_nxt;
            rd_ptr <= rd_ptr_nxt;
            if (flush || pop)          word_idx <= WORD_HDR;
            else if (rd_acc && rd_hit) word_idx <= word_idx + 2'd1;
        end
    end

    // Control registers and drop accounting; clear beats a simultaneous drop.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            en        <= 1'b0;
            mask      <= 32'hFFFF_FFFF;
            threshold <= 16'd0;
            overflow  <= 1'b0;
            dropped   <= 32'd0;
        end else begin
            if (clear) begin
                overflow <= 1'b0;
                dropped  <= 32'd0;
            end else if (drop) begin
                overflow <= 1'b1;
                if (dropped != 32'hFFFF_FFFF) dropped <= dropped + 32'd1;
            end
            if (wr_acc) begin
                case (address)
                    ADDR_MASK:      mask      <= writedata;
                    ADDR_THRESHOLD: threshold <= writedata[15:0];
                    ADDR_CONTROL:   en        <= writedata[0];
                    default:        ;
                endcase
            end
        end
    end

    // Read data selection for the registered Avalon response.
    always_comb begin
        rd_mux = BAD_CODE;
        case (address)
            ADDR_DATA:      if (!empty) rd_mux = rec_word(head_rec, word_idx);
            ADDR_FILL:      rd_mux = 32'(fill);
            ADDR_STATUS:    rd_mux = {29'b0, overflow, full, empty};
            ADDR_DROPPED:   rd_mux = dropped;
            ADDR_MASK:      rd_mux = mask;
            ADDR_THRESHOLD: rd_mux = {16'h0, threshold};
            ADDR_CONTROL:   rd_mux = {31'b0, en};
            default:        rd_mux = BAD_CODE;
        endcase
    end

    // Two-cycle read: register data on the wait cycle, apply side effects on the accepted cycle.
    // rd_hit remembers whether the wait cycle actually saw a head record to return.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_phase <= 1'b0;
            rd_hit   <= 1'b0;
            readdata <= 32'd0;
        end else if (rd_acc) begin
            rd_phase <= 1'b0;
        end else if (read) begin
            rd_phase <= 1'b1;
            readdata <= rd_mux;
            rd_hit   <= (address == ADDR_DATA) && !empty;
        end
    end

endmodule

// File: tb/tb_myo_status_recorder.sv
// Randomized and directed checks of the status recorder against a queue-based record model.
// Latency: bench drives one cycle per strobe and samples #1 after the active edge.
// Backpressure: reads wait on waitrequest with a bounded cycle budget.
module tb_myo_status_recorder;

    localparam int NM      = 7;
    localparam int DEPTH   = 64;
    localparam int CLK_HZ  = 50_000_000;
    localparam int TICK_US = CLK_HZ / 1_000_000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        sample_valid = 1'b0;
    logic [7:0]  sample_motor = '0;
    logic [31:0] sample_position = '0;
    logic [15:0] sample_velocity = '0, sample_current = '0, sample_displacement = '0;
    logic [3:0]  address = '0;
    logic        read = 1'b0, write = 1'b0;
    logic [31:0] writedata = '0;
    logic [31:0] readdata;
    logic        waitrequest, irq_level;

    myo_status_recorder #(.NUMBER_OF_MOTORS(NM), .DEPTH(DEPTH), .CLOCK_SPEED_HZ(CLK_HZ)) dut (
        .clock(clock), .reset(reset), .sample_valid(sample_valid), .sample_motor(sample_motor),
        .sample_position(sample_position), .sample_velocity(sample_velocity),
        .sample_current(sample_current), .sample_displacement(sample_displacement),
        .address(address), .read(read), .write(write), .writedata(writedata),
        .readdata(readdata), .waitrequest(waitrequest), .irq_level(irq_level)
    );

    always #5 clock = ~clock;

    // Clock edges since reset release: the timestamp is this divided by TICK_US.
    int cyc = 0;
    always @(posedge clock) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state.
    logic [127:0] mq [$];
    int           widx;
    bit           m_en, m_ovf;
    logic [31:0]  m_mask, m_drop;
    logic [15:0]  m_thr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        widx = 0; m_en = 0; m_ovf = 0;
        m_mask = 32'hFFFF_FFFF; m_drop = 0; m_thr = 0;
    endtask

    function automatic logic model_irq();
        return (m_thr != 0) && (mq.size() >= int'(m_thr));
    endfunction

    task automatic model_sample(input logic [7:0] m, input logic [31:0] p,
                                input logic [15:0] v, input logic [15:0] c, input logic [15:0] ds);
        logic [23:0] t;
        t = 24'(cyc / TICK_US);
        if (m_en && (int'(m) < NM) && m_mask[m[4:0]]) begin
            if (mq.size() < DEPTH) mq.push_back({16'h0, ds, v, c, p, m, t});
            else begin
                m_ovf = 1;
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 1;
            end
        end
    endtask

    task automatic model_read(input logic [3:0] a, output logic [31:0] e);
        logic [127:0] h;
        case (a)
            4'd0: begin
                if (mq.size() == 0) e = 32'hDEADBEEF;
                else begin
                    h = mq[0];
                    e = h[32*widx +: 32];
                    widx++;
                    if (widx == 4) begin
                        mq.delete(0);
                        widx = 0;
                    end
                end
            end
            4'd1:    e = 32'(mq.size());
            4'd2:    e = {29'b0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
            4'd3:    e = m_drop;
            4'd4:    e = m_mask;
            4'd5:    e = {16'h0, m_thr};
            4'd6:    e = {31'b0, m_en};
            default: e = 32'hDEADBEEF;
        endcase
    endtask

    task automatic model_write(input logic [3:0] a, input logic [31:0] d);
        case (a)
            4'd2: begin
                if (d[0]) begin mq.delete(); widx = 0; end
                if (d[1]) begin m_ovf = 0; m_drop = 0; end
            end
            4'd4: m_mask = d;
            4'd5: m_thr = d[15:0];
            4'd6: m_en = d[0];
            default: ;
        endcase
    endtask

    task automatic drive_sample(input logic [7:0] m, input logic [31:0] p,
                                input logic [15:0] v, input logic [15:0] c, input logic [15:0] ds);
        sample_valid = 1'b1; sample_motor = m; sample_position = p;
        sample_velocity = v; sample_current = c; sample_displacement = ds;
    endtask

    task automatic send(input logic [7:0] m, input logic [31:0] p,
                        input logic [15:0] v, input logic [15:0] c, input logic [15:0] ds);
        @(posedge clock); #1;
        drive_sample(m, p, v, c, ds);
        model_sample(m, p, v, c, ds);
        @(posedge clock); #1;
        sample_valid = 1'b0;
        check_val("irq", {31'b0, irq_level}, {31'b0, model_irq()});
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        int n;
        @(posedge clock); #1;
        address = a; read = 1'b1; n = 0;
        do begin
            @(posedge clock); #1;
            n++;
        end while (waitrequest && n < 8);
        check_val("rd_wait", n, 1);
        d = readdata;
        @(posedge clock); #1;
        read = 1'b0;
    endtask

    task automatic rd_chk(input logic [3:0] a, input string tag, output logic [31:0] d);
        logic [31:0] e;
        bus_rd(a, d);
        model_read(a, e);
        check_val(tag, d, e);
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        address = a; writedata = d; write = 1'b1;
        @(posedge clock); #1;
        write = 1'b0;
        model_write(a, d);
    endtask

    logic [31:0] d, e, w0a, w0b, delta;
    int          r;
    logic [3:0]  ra;

    initial begin
        model_reset();
        #2 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst_readdata", readdata, 32'h0);
        check_val("rst_wait", {31'b0, waitrequest}, 32'h0);
        check_val("rst_irq", {31'b0, irq_level}, 32'h0);
        reset = 1'b0;

        // Reset register values, then a sample while disabled is ignored.
        for (int a = 1; a <= 7; a++) rd_chk(4'(a), "rst_reg", d);
        send(8'd2, 32'h1, 16'h1, 16'h1, 16'h1);
        rd_chk(4'd1, "dis_fill", d);

        // Single record readout.
        bus_wr(4'd6, 32'h1);
        send(8'd2, 32'h12345678, 16'hFFFB, 16'd100, 16'd7);
        rd_chk(4'd1, "one_fill", d);
        check_val("one_fill_const", d, 32'd1);
        rd_chk(4'd0, "one_w0", d);
        check_val("one_motor", {24'h0, d[31:24]}, 32'h2);
        rd_chk(4'd0, "one_w1", d);
        rd_chk(4'd0, "one_w2", d);
        check_val("one_w2_const", d, 32'hFFFB0064);
        rd_chk(4'd0, "one_w3", d);
        rd_chk(4'd1, "one_fill_after", d);
        rd_chk(4'd2, "one_status", d);
        check_val("one_status_const", d, 32'h1);
        rd_chk(4'd0, "empty_data", d);

        // Overflow and clear.
        for (int i = 0; i < DEPTH + 3; i++)
            send(8'(i % NM), $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
        rd_chk(4'd1, "full_fill", d);
        rd_chk(4'd2, "full_status", d);
        check_val("full_status_const", d, 32'h6);
        rd_chk(4'd3, "full_dropped", d);
        bus_wr(4'd2, 32'h2);
        rd_chk(4'd2, "clr_status", d);
        rd_chk(4'd3, "clr_dropped", d);

        // Pop of W3 and a sample in the same cycle while full.
        for (int i = 0; i < 3; i++) rd_chk(4'd0, "co_head", d);
        @(posedge clock); #1;
        address = 4'd0; read = 1'b1;
        @(posedge clock); #1;
        check_val("co_wait", {31'b0, waitrequest}, 32'h0);
        d = readdata;
        drive_sample(8'd5, 32'hCAFEF00D, 16'h1234, 16'h5678, 16'h9ABC);
        model_read(4'd0, e);
        check_val("co_w3", d, e);
        model_sample(8'd5, 32'hCAFEF00D, 16'h1234, 16'h5678, 16'h9ABC);
        @(posedge clock); #1;
        read = 1'b0; sample_valid = 1'b0;
        rd_chk(4'd1, "co_fill", d);
        check_val("co_fill_const", d, DEPTH);
        rd_chk(4'd3, "co_dropped", d);

        // Flush during a record readout.
        rd_chk(4'd0, "fl_w0", d);
        rd_chk(4'd0, "fl_w1", d);
        bus_wr(4'd2, 32'h1);
        rd_chk(4'd1, "fl_fill", d);
        rd_chk(4'd0, "fl_data", d);
        send(8'd1, 32'h0BADF00D, 16'h1, 16'h2, 16'h3);
        for (int i = 0; i < 4; i++) rd_chk(4'd0, "fl_new", d);

        // Capture mask and out-of-range motor.
        bus_wr(4'd4, 32'h4);
        for (int m = 0; m < NM; m++) send(8'(m), 32'(m), 16'h0, 16'h0, 16'h0);
        send(8'd9, 32'h9, 16'h0, 16'h0, 16'h0);
        rd_chk(4'd1, "mask_fill", d);
        rd_chk(4'd3, "mask_dropped", d);
        rd_chk(4'd0, "mask_w0", d);
        check_val("mask_motor", {24'h0, d[31:24]}, 32'h2);
        bus_wr(4'd2, 32'h1);
        bus_wr(4'd4, 32'hFFFF_FFFF);

        // Threshold interrupt.
        bus_wr(4'd5, 32'h3);
        for (int i = 0; i < 4; i++) send(8'd3, 32'(i), 16'h0, 16'h0, 16'h0);
        rd_chk(4'd5, "thr_reg", d);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5) begin
                send(8'($urandom_range(0, 9)), $urandom, 16'($urandom), 16'($urandom), 16'($urandom));
            end else if (r < 8) begin
                ra = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 8));
                if (ra == 4'd8) ra = 4'hF;
                rd_chk(ra, "rnd_rd", d);
                check_val("rnd_irq", {31'b0, irq_level}, {31'b0, model_irq()});
            end else begin
                case ($urandom_range(0, 5))
                    0: bus_wr(4'd4, $urandom | 32'h0000_0015);
                    1: bus_wr(4'd5, 32'($urandom_range(0, 12)));
                    2: bus_wr(4'd6, ($urandom_range(0, 4) == 0) ? 32'h0 : 32'h1);
                    3: bus_wr(4'd2, ($urandom_range(0, 5) == 0) ? 32'h1 : 32'(2 * $urandom_range(0, 1)));
                    4: bus_wr(4'($urandom_range(0, 1) * 3), $urandom);
                    default: bus_wr(4'd1, $urandom);
                endcase
            end
        end
        for (int a = 1; a <= 6; a++) rd_chk(4'(a), "rnd_final", d);

        // Timestamp spacing over one millisecond.
        bus_wr(4'd2, 32'h3);
        bus_wr(4'd4, 32'hFFFF_FFFF);
        bus_wr(4'd6, 32'h1);
        send(8'd4, 32'hA, 16'h0, 16'h0, 16'h0);
        repeat (49998) @(posedge clock);
        send(8'd4, 32'hB, 16'h0, 16'h0, 16'h0);
        rd_chk(4'd0, "ts_a0", w0a);
        for (int i = 0; i < 3; i++) rd_chk(4'd0, "ts_a", d);
        rd_chk(4'd0, "ts_b0", w0b);
        for (int i = 0; i < 3; i++) rd_chk(4'd0, "ts_b", d);
        delta = (w0b - w0a) & 32'h00FF_FFFF;
        check_val("ts_delta_ok", {31'b0, (delta >= 32'd999 && delta <= 32'd1001)}, 32'h1);

        // Reset in the middle of a read.
        bus_wr(4'd5, 32'h1);
        send(8'd0, 32'h77, 16'h0, 16'h0, 16'h0);
        @(posedge clock); #1;
        address = 4'd0; read = 1'b1;
        @(posedge clock); #3;
        reset = 1'b1; read = 1'b0;
        model_reset();
        #1;
        check_val("mr_readdata", readdata, 32'h0);
        check_val("mr_wait", {31'b0, waitrequest}, 32'h0);
        check_val("mr_irq", {31'b0, irq_level}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        for (int a = 0; a <= 7; a++) rd_chk(4'(a), "mr_reg", d);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
